pipeline_exec_controller: RTL and testbench

//  Sequences the MIPS pipeline for the debug unit. Generates the global i_valid enable and a fetch freeze.

---
 rtl/pipeline_exec_controller_pkg.sv | 18 +
 rtl/pipeline_exec_controller.sv | 135 +++++++++++++
 tb/tb_pipeline_exec_controller.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_exec_controller_pkg.sv
// Shared definitions for the debug-unit pipeline execution controller:
// command codes, FSM state encodings and the default HALT encoding.
package pipeline_exec_controller_pkg;

  localparam logic [1:0] CMD_RUN   = 2'b00;
  localparam logic [1:0] CMD_STEP  = 2'b01;
  localparam logic [1:0] CMD_STOP  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_STEP   = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipeline_exec_controller.sv
// Debug-unit pipeline sequencer: free-run, single-step, halt detect with drain,
// stop. Drives the global stage enable, a fetch freeze and a saturating cycle counter.
module pipeline_exec_controller
  import pipeline_exec_controller_pkg::*;
#(
  parameter int unsigned         NB_DATA    = 32,
  parameter int unsigned         NB_COUNT   = 32,
  parameter int unsigned         PIPE_DEPTH = 5,
  parameter logic [NB_DATA-1:0]  HALT_INSTR = NB_DATA'(HALT_INSTR_DEFAULT)
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  input  logic [1:0]          i_cmd,
  input  logic [NB_DATA-1:0]  i_instruction,
  output logic                o_valid,
  output logic                o_fetch_hold,
  output logic                o_cmd_error,
  output logic                o_step_done,
  output logic                o_running,
  output logic                o_halted,
  output logic [NB_COUNT-1:0] o_cycle_count
);

  localparam int unsigned NB_DRAIN = (PIPE_DEPTH > 2) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(PIPE_DEPTH - 1);

  logic [2:0]          state, state_nxt;
  logic [NB_DRAIN-1:0] drain_cnt, drain_nxt;
  logic                step_drain, step_drain_nxt;
  logic                err_nxt, done_nxt, clr_cnt;
  logic                halt_det;

  assign halt_det = o_valid & ~o_fetch_hold & (i_instruction == HALT_INSTR);

  always_comb begin
    state_nxt      = state;
    drain_nxt      = drain_cnt;
    step_drain_nxt = step_drain;
    err_nxt        = 1'b0;
    done_nxt       = 1'b0;
    clr_cnt        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          case (i_cmd)
            CMD_RUN:   state_nxt = ST_RUN;
            CMD_STEP:  state_nxt = ST_STEP;
            CMD_CLEAR: clr_cnt   = 1'b1;
            default:   err_nxt   = 1'b1;
          endcase
        end
      end
      ST_RUN: begin
        // STOP outranks a HALT seen in the same cycle
        if (i_cmd_valid && (i_cmd == CMD_STOP)) begin
          state_nxt = ST_IDLE;
        end else begin
          err_nxt = i_cmd_valid;
          if (halt_det) begin
            state_nxt      = ST_DRAIN;
            drain_nxt      = DRAIN_LOAD;
            step_drain_nxt = 1'b0;
          end
        end
      end
      ST_STEP: begin
        err_nxt = i_cmd_valid;
        if (halt_det) begin
          state_nxt      = ST_DRAIN;
          drain_nxt      = DRAIN_LOAD;
          step_drain_nxt = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (i_cmd_valid && (i_cmd == CMD_STOP)) begin
          state_nxt = ST_IDLE;
        end else begin
          err_nxt   = i_cmd_valid;
          drain_nxt = drain_cnt - NB_DRAIN'(1);
          if (drain_cnt == NB_DRAIN'(1)) begin
            state_nxt = ST_HALTED;
            done_nxt  = step_drain;
          end
        end
      end
      ST_HALTED: begin
        if (i_cmd_valid) begin
          if (i_cmd == CMD_CLEAR) begin
            state_nxt = ST_IDLE;
            clr_cnt   = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are true flop outputs
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state         <= ST_IDLE;
      drain_cnt     <= '0;
      step_drain    <= 1'b0;
      o_valid       <= 1'b0;
      o_fetch_hold  <= 1'b0;
      o_cmd_error   <= 1'b0;
      o_step_done   <= 1'b0;
      o_running     <= 1'b0;
      o_halted      <= 1'b0;
      o_cycle_count <= '0;
    end else begin
      state        <= state_nxt;
      drain_cnt    <= drain_nxt;
      step_drain   <= step_drain_nxt;
      o_valid      <= (state_nxt == ST_RUN) || (state_nxt == ST_STEP) ||
                      (state_nxt == ST_DRAIN);
      o_fetch_hold <= (state_nxt == ST_DRAIN) || (state_nxt == ST_HALTED);
      o_cmd_error  <= err_nxt;
      o_step_done  <= done_nxt;
      o_running    <= (state_nxt == ST_RUN);
      o_halted     <= (state_nxt == ST_HALTED);
      if (clr_cnt)
        o_cycle_count <= '0;
      else if (o_valid && (o_cycle_count != '1))
        o_cycle_count <= o_cycle_count + NB_COUNT'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_exec_controller.sv
// Scoreboard bench for pipeline_exec_controller with a minimal fetch PC model;
// a second 4-bit-counter instance covers counter saturation.
module tb_pipeline_exec_controller;
  import pipeline_exec_controller_pkg::*;

  localparam logic [5:0] S_IDLE  = 6'b000000;
  localparam logic [5:0] S_RUN   = 6'b100010;
  localparam logic [5:0] S_STEP  = 6'b100000;
  localparam logic [5:0] S_DRAIN = 6'b110000;
  localparam logic [5:0] S_HALT  = 6'b010001;
  localparam logic [5:0] B_ERR   = 6'b001000;
  localparam logic [5:0] B_DONE  = 6'b000100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic        c4_valid = 1'b0;
  logic [1:0]  c4_cmd = 2'b00;
  logic [31:0] instr;
  logic        valid, hold, err, done, running, halted;
  logic [31:0] cnt;
  logic        v4, h4, e4, d4, r4, hl4;
  logic [3:0]  cnt4;

  logic [31:0] pc;
  logic        halt_en = 1'b0;
  logic [31:0] halt_addr = 32'd7;

  always #5 clk = ~clk;

  pipeline_exec_controller dut (
    .i_clock(clk), .i_reset(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .i_instruction(instr), .o_valid(valid), .o_fetch_hold(hold),
    .o_cmd_error(err), .o_step_done(done), .o_running(running),
    .o_halted(halted), .o_cycle_count(cnt)
  );

  pipeline_exec_controller #(.NB_COUNT(4)) dut4 (
    .i_clock(clk), .i_reset(rst_n), .i_cmd_valid(c4_valid), .i_cmd(c4_cmd),
    .i_instruction(32'h0), .o_valid(v4), .o_fetch_hold(h4),
    .o_cmd_error(e4), .o_step_done(d4), .o_running(r4),
    .o_halted(hl4), .o_cycle_count(cnt4)
  );

  // Fetch model: instruction memory holds its own address except the HALT slot
  assign instr = (halt_en && (pc == halt_addr)) ? 32'hFFFF_FFFF : pc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= 32'd0;
    else if (valid && !hold) pc <= pc + 32'd1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    int          dsel;
    logic [5:0]  val;
    logic [31:0] cnt;
    bit          chk_pc;
    logic [31:0] pc;
  } exp_t;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic push_exp(int off, string nm, logic [5:0] v, logic [31:0] c,
                          bit cp, logic [31:0] p, int d);
    exp_t e;
    e.cyc = cyc + off; e.name = nm; e.dsel = d; e.val = v;
    e.cnt = c; e.chk_pc = cp; e.pc = p;
    sbq.push_back(e);
  endtask

  // Monitor: pops every expectation due this cycle; any pulse on the main DUT
  // that no expectation accounts for is a failure on its own.
  exp_t        me;
  bit          pulse_cov;
  logic [5:0]  obs;
  logic [31:0] ocnt;
  always @(negedge clk) begin
    pulse_cov = 1'b0;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      me = sbq.pop_front();
      n_total++;
      if (me.cyc < cyc) begin
        $display("FAIL %s stale at cyc=%0d required cyc=%0d", me.name, cyc, me.cyc);
      end else begin
        obs  = (me.dsel == 0) ? {valid, hold, err, done, running, halted}
                              : {v4, h4, e4, d4, r4, hl4};
        ocnt = (me.dsel == 0) ? cnt : {28'd0, cnt4};
        if (me.dsel == 0) pulse_cov = 1'b1;
        if (obs == me.val && ocnt == me.cnt && (!me.chk_pc || pc == me.pc))
          n_pass++;
        else
          $display("FAIL %s cyc=%0d outs=%b req=%b count=%0d req=%0d pc=%0d req=%0d",
                   me.name, cyc, obs, me.val, ocnt, me.cnt, pc, me.pc);
      end
    end
    if (!pulse_cov && (err || done)) begin
      n_total++;
      $display("FAIL unexpected_pulse cyc=%0d err=%b done=%b required 0 0", cyc, err, done);
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(int d, logic [1:0] c);
    if (d == 0) begin cmd_valid = 1'b1; cmd = c; end
    else        begin c4_valid = 1'b1; c4_cmd = c; end
    tick(1);
    cmd_valid = 1'b0;
    c4_valid  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    push_exp(0, "reset", S_IDLE, 0, 1, 0, 0);
    push_exp(0, "reset4", S_IDLE, 0, 0, 0, 1);
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    tick(1);

    // Free run for ten cycles, then stop
    do_reset();
    send(0, CMD_RUN);
    for (int k = 0; k < 10; k++) push_exp(k, "run_pc", S_RUN, k, 1, k, 0);
    tick(9);
    send(0, CMD_STOP);
    push_exp(0, "stop", S_IDLE, 10, 1, 10, 0);
    push_exp(2, "stop_frozen", S_IDLE, 10, 1, 10, 0);
    tick(3);

    // Three single steps, four cycles apart
    send(0, CMD_CLEAR);
    push_exp(0, "clear_idle", S_IDLE, 0, 1, 10, 0);
    tick(1);
    for (int s = 0; s < 3; s++) begin
      send(0, CMD_STEP);
      push_exp(0, "step_valid", S_STEP, s, 1, 10 + s, 0);
      push_exp(1, "step_done", B_DONE, s + 1, 1, 11 + s, 0);
      push_exp(2, "step_idle", S_IDLE, s + 1, 1, 11 + s, 0);
      tick(3);
    end
    push_exp(0, "steps_total", S_IDLE, 3, 1, 13, 0);
    tick(1);

    // Illegal commands in IDLE and RUN
    send(0, CMD_STOP);
    push_exp(0, "stop_in_idle", B_ERR, 3, 1, 13, 0);
    push_exp(1, "err_one_cycle", S_IDLE, 3, 1, 13, 0);
    tick(1);
    send(0, CMD_RUN);
    push_exp(0, "run2", S_RUN, 3, 1, 13, 0);
    tick(2);
    send(0, CMD_RUN);
    push_exp(0, "run_in_run", S_RUN | B_ERR, 6, 1, 16, 0);
    push_exp(1, "run_uninterrupted", S_RUN, 7, 1, 17, 0);
    tick(1);
    send(0, CMD_STOP);
    push_exp(0, "stop_after_err", S_IDLE, 8, 1, 18, 0);
    tick(1);

    // HALT at address 7: drain, halted, illegal RUN, CLEAR
    do_reset();
    halt_en = 1'b1; halt_addr = 32'd7;
    send(0, CMD_RUN);
    for (int k = 0; k < 8; k++)   push_exp(k, "run_to_halt", S_RUN, k, 1, k, 0);
    for (int k = 8; k < 12; k++)  push_exp(k, "drain", S_DRAIN, k, 1, 8, 0);
    for (int k = 12; k < 15; k++) push_exp(k, "halted", S_HALT, 12, 1, 8, 0);
    tick(14);
    send(0, CMD_RUN);
    push_exp(0, "run_in_halted", S_HALT | B_ERR, 12, 1, 8, 0);
    push_exp(1, "halted_stays", S_HALT, 12, 1, 8, 0);
    tick(1);
    send(0, CMD_CLEAR);
    push_exp(0, "clear_from_halted", S_IDLE, 0, 1, 8, 0);
    push_exp(1, "clear_settled", S_IDLE, 0, 1, 8, 0);
    tick(2);

    // STEP landing on HALT: done pulse only on entry to HALTED
    do_reset();
    halt_en = 1'b1; halt_addr = 32'd0;
    send(0, CMD_STEP);
    push_exp(0, "step_on_halt", S_STEP, 0, 1, 0, 0);
    for (int k = 1; k < 5; k++) push_exp(k, "step_drain", S_DRAIN, k, 1, 1, 0);
    push_exp(5, "step_halted_done", S_HALT | B_DONE, 5, 1, 1, 0);
    push_exp(6, "step_halted", S_HALT, 5, 1, 1, 0);
    tick(6);
    send(0, CMD_CLEAR);
    push_exp(0, "clear_after_step", S_IDLE, 0, 1, 1, 0);
    tick(1);

    // STOP aborts a drain in progress
    halt_addr = 32'd3;
    send(0, CMD_RUN);
    for (int k = 0; k < 3; k++) push_exp(k, "run_pre_abort", S_RUN, k, 1, 1 + k, 0);
    push_exp(3, "drain_pre_abort", S_DRAIN, 3, 1, 4, 0);
    tick(3);
    send(0, CMD_STOP);
    push_exp(0, "stop_aborts_drain", S_IDLE, 4, 1, 4, 0);
    tick(1);

    // Reset asserted in the second drain cycle
    do_reset();
    halt_en = 1'b1; halt_addr = 32'd7;
    send(0, CMD_RUN);
    for (int k = 0; k < 8; k++) push_exp(k, "run_pre_reset", S_RUN, k, 1, k, 0);
    push_exp(8, "drain1", S_DRAIN, 8, 1, 8, 0);
    tick(9);
    rst_n = 1'b0;
    push_exp(0, "async_reset", S_IDLE, 0, 1, 0, 0);
    tick(2);
    rst_n = 1'b1;
    halt_en = 1'b0;
    send(0, CMD_RUN);
    push_exp(0, "restart_pc0", S_RUN, 0, 1, 0, 0);
    push_exp(1, "restart_pc1", S_RUN, 1, 1, 1, 0);
    tick(1);
    send(0, CMD_STOP);
    push_exp(0, "restart_stop", S_IDLE, 2, 1, 2, 0);
    tick(1);

    // 4-bit counter saturates at 15 over 20 valid cycles
    send(1, CMD_RUN);
    for (int k = 0; k < 20; k++) push_exp(k, "sat", S_RUN, (k < 15) ? k : 15, 0, 0, 1);
    tick(19);
    send(1, CMD_STOP);
    push_exp(0, "sat_final", S_IDLE, 15, 0, 0, 1);
    tick(2);

    if (sbq.size() != 0) begin
      n_total++;
      $display("FAIL leftover_expectations pending=%0d required 0", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
